// File: rtl/alu_arbiter_if.sv
// Bundle between the two requesters, the response consumer and the shared ALU.
// The slave modport is the arbiter side and the master modport is the environment side.
interface alu_arbiter_if #(
    parameter int WIDTH  = 64,
    parameter int CODE_W = 4
);
    // Valid/ready: a transfer occurs in a cycle where valid and ready are both high.
    // Valid may drop before ready is seen. While valid is held, the payload stays stable.
    // reqN_ready is a combinational single-cycle grant pulse.
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_rs1;
    logic [WIDTH-1:0]  req0_rs2;
    logic [CODE_W-1:0] req0_code;
    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_rs1;
    logic [WIDTH-1:0]  req1_rs2;
    logic [CODE_W-1:0] req1_code;
    logic [WIDTH-1:0]  alu_rs1;
    logic [WIDTH-1:0]  alu_rs2;
    logic [CODE_W-1:0] alu_code;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_overflow;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_overflow;
    logic              rsp_zero;

    modport slave (
        input  req0_valid, req0_rs1, req0_rs2, req0_code,
        output req0_ready,
        input  req1_valid, req1_rs1, req1_rs2, req1_code,
        output req1_ready,
        output alu_rs1, alu_rs2, alu_code,
        input  alu_result, alu_overflow, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_rs1, req0_rs2, req0_code,
        input  req0_ready,
        output req1_valid, req1_rs1, req1_rs2, req1_code,
        input  req1_ready,
        input  alu_rs1, alu_rs2, alu_code,
        output alu_result, alu_overflow, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; the response is registered and held until taken.
// Define ALU_ARB_PIPE_EN to grant the next request in the same cycle a response is consumed.
module alu_arbiter #(
    parameter int WIDTH  = 64,
    parameter int CODE_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_arbiter_if.slave bus,
    output logic [1:0]  o_dbg_state,
    output logic        o_dbg_rr_ptr
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rr_ptr;
    logic [WIDTH-1:0]  r_rs1;
    logic [WIDTH-1:0]  r_rs2;
    logic [CODE_W-1:0] r_code;
    logic              r_id;
    logic [WIDTH-1:0]  r_rsp_result;
    logic              r_rsp_overflow;
    logic              r_rsp_zero;
    logic              w_grant_win;
    logic              w_grant;
    logic              w_gnt_id;

`ifdef ALU_ARB_PIPE_EN
    assign w_grant_win = (r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready);
`else
    assign w_grant_win = (r_state == S_IDLE);
`endif

    // rst_n gates the grant so readies read 0 while reset is asserted.
    assign w_gnt_id = (bus.req0_valid && bus.req1_valid) ? r_rr_ptr : bus.req1_valid;
    assign w_grant  = rst_n && w_grant_win && (bus.req0_valid || bus.req1_valid);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_nxt = w_grant ? S_EXEC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr       <= 1'b0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_code         <= '0;
            r_id           <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rs1    <= w_gnt_id ? bus.req1_rs1  : bus.req0_rs1;
                r_rs2    <= w_gnt_id ? bus.req1_rs2  : bus.req0_rs2;
                r_code   <= w_gnt_id ? bus.req1_code : bus.req0_code;
                r_id     <= w_gnt_id;
                r_rr_ptr <= ~w_gnt_id;
            end
            // The ALU is purely combinational on the latched operands during EXEC.
            if (r_state == S_EXEC) begin
                r_rsp_result   <= bus.alu_result;
                r_rsp_overflow <= bus.alu_overflow;
                r_rsp_zero     <= bus.alu_zero;
            end
        end
    end

    assign bus.req0_ready   = w_grant && !w_gnt_id;
    assign bus.req1_ready   = w_grant && w_gnt_id;
    assign bus.alu_rs1      = r_rs1;
    assign bus.alu_rs2      = r_rs2;
    assign bus.alu_code     = r_code;
    assign bus.rsp_valid    = (r_state == S_RESP);
    assign bus.rsp_id       = r_id;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_overflow = r_rsp_overflow;
    assign bus.rsp_zero     = r_rsp_zero;
    assign o_dbg_state      = r_state;
    assign o_dbg_rr_ptr     = r_rr_ptr;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a behavioural ALU and a queue-based response model.
module tb_alu_arbiter;
`ifdef ALU_ARB_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic       dbg_rr;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [66:0] exp_q[$];

    alu_arbiter_if #(.WIDTH(64), .CODE_W(4)) bus ();

    alu_arbiter #(.WIDTH(64), .CODE_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .o_dbg_state  (dbg_state),
        .o_dbg_rr_ptr (dbg_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Behavioural ALU: logic ops, signed-overflow add/sub, unknown codes give 0.
    function automatic logic [65:0] ref_alu(input logic [3:0] code, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (code)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin r = a + b; v = (a[63] == b[63]) && (r[63] != a[63]); end
            4'd3: begin r = a - b; v = (a[63] != b[63]) && (r[63] != a[63]); end
            default: r = '0;
        endcase
        return {v, (r == 64'd0), r};
    endfunction

    always_comb {bus.alu_overflow, bus.alu_zero, bus.alu_result} = ref_alu(bus.alu_code, bus.alu_rs1, bus.alu_rs2);

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [67:0] rsp_vec();
        return {bus.rsp_valid, bus.rsp_id, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result};
    endfunction

    function automatic logic [1:0] rdy();
        return {bus.req0_ready, bus.req1_ready};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return {64{1'b1}};
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rnd_code();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(4, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    task automatic set_req(input bit r, input bit v, input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        if (!r) begin
            bus.req0_valid = v; bus.req0_rs1 = a; bus.req0_rs2 = b; bus.req0_code = c;
        end else begin
            bus.req1_valid = v; bus.req1_rs1 = a; bus.req1_rs2 = b; bus.req1_code = c;
        end
    endtask

    task automatic set_valid(input bit r, input bit v);
        if (!r) bus.req0_valid = v;
        else    bus.req1_valid = v;
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Starts just after a rising edge; returns just after the edge following the grant, valid dropped.
    task automatic wait_ready(input string tag, input bit r, input int bound, output int lat);
        bit hit;
        hit = 1'b0;
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (r ? bus.req1_ready : bus.req0_ready) begin hit = 1'b1; lat = i; break; end
            @(posedge clk); #1;
        end
        check(tag, 72'(hit), 72'd1);
        @(posedge clk); #1;
        set_valid(r, 1'b0);
    endtask

    task automatic wait_rsp(input string tag, input logic [67:0] exp, input int bound, output int lat);
        logic [67:0] cap;
        cap = '0;
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin cap = rsp_vec(); lat = i; break; end
            @(posedge clk); #1;
        end
        check(tag, 72'(cap), 72'(exp));
        @(posedge clk); #1;
    endtask

    // Queue-based model: one op in flight, response visible two cycles after its grant,
    // arbiter free when nothing is outstanding (or, pipelined, when the response leaves now).
    task automatic run_model(input int ncyc, input bit sat, output int first_g, output int g11);
        logic [63:0] op_rs1[2];
        logic [63:0] op_rs2[2];
        logic [3:0]  op_code[2];
        bit          op_v[2];
        bit          g[2];
        bit          last_gnt, exp_rv, hs, free, exp_g, exp_id;
        int          gnt_cyc, gcount;
        exp_q.delete();
        last_gnt = 1'b1;
        gnt_cyc  = -10;
        gcount   = 0;
        first_g  = -1;
        g11      = -1;
        for (int r = 0; r < 2; r++) begin
            op_rs1[r] = rnd64(); op_rs2[r] = rnd64(); op_code[r] = rnd_code();
            op_v[r] = sat ? 1'b1 : 1'($urandom_range(0, 1));
            set_req(1'(r), op_v[r], op_rs1[r], op_rs2[r], op_code[r]);
        end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            exp_rv = (exp_q.size() != 0) && (c - gnt_cyc >= 2);
            check("m_rsp_valid", 72'(bus.rsp_valid), 72'(exp_rv));
            if (exp_rv) check("m_rsp_data", 72'({bus.rsp_id, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result}), 72'(exp_q[0]));
            hs     = exp_rv && bus.rsp_ready;
            free   = (exp_q.size() == 0) || (PIPE && hs);
            exp_g  = free && (op_v[0] || op_v[1]);
            exp_id = (op_v[0] && op_v[1]) ? ~last_gnt : op_v[1];
            check("m_ready", 72'(rdy()), exp_g ? (exp_id ? 72'b01 : 72'b10) : 72'b00);
            if (hs) void'(exp_q.pop_front());
            g[0] = exp_g && !exp_id;
            g[1] = exp_g && exp_id;
            if (exp_g) begin
                exp_q.push_back({exp_id, ref_alu(op_code[exp_id], op_rs1[exp_id], op_rs2[exp_id])});
                gnt_cyc  = c;
                last_gnt = exp_id;
                gcount++;
                if (gcount == 1)  first_g = c;
                if (gcount == 11) g11 = c;
            end
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                if (sat) begin
                    op_v[r] = 1'b1;
                    if (g[r]) begin op_rs1[r] = rnd64(); op_rs2[r] = rnd64(); op_code[r] = rnd_code(); end
                end else if (op_v[r] && g[r]) begin
                    op_v[r] = ($urandom_range(0, 9) < 7);
                    op_rs1[r] = rnd64(); op_rs2[r] = rnd64(); op_code[r] = rnd_code();
                end else if (op_v[r]) begin
                    if ($urandom_range(0, 9) == 0) op_v[r] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    op_v[r] = 1'b1;
                    op_rs1[r] = rnd64(); op_rs2[r] = rnd64(); op_code[r] = rnd_code();
                end
                set_req(1'(r), op_v[r], op_rs1[r], op_rs2[r], op_code[r]);
            end
            bus.rsp_ready = sat ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        int lat, first_g, g11;
        // Reset with both requesters asserting: everything must read 0.
        rst_n = 1'b1;
        set_req(1'b0, 1'b1, 64'd11, 64'd22, 4'd2);
        set_req(1'b1, 1'b1, 64'd33, 64'd44, 4'd3);
        bus.rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 72'({rdy(), bus.rsp_valid, bus.rsp_id, bus.rsp_overflow, bus.rsp_zero, dbg_state, dbg_rr}), 72'd0);
        check("rst_rsp_result", 72'(bus.rsp_result), 72'd0);
        check("rst_alu_ops", 72'({bus.alu_rs1[31:0], bus.alu_rs2[31:0], bus.alu_code}), 72'd0);
        @(posedge clk); #1;
        set_valid(1'b0, 1'b0);
        set_valid(1'b1, 1'b0);
        rst_n = 1'b1;

        // 1: req0 ADD 5+7.
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 64'd5, 64'd7, 4'd2);
        bus.rsp_ready = 1'b1;
        wait_ready("t1_gnt", 1'b0, 1, lat);
        @(negedge clk);
        check("t1_exec_alu", 72'({bus.alu_rs1[15:0], bus.alu_rs2[15:0], bus.alu_code, bus.rsp_valid}), 72'({16'd5, 16'd7, 4'd2, 1'b0}));
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_rsp", 72'(rsp_vec()), 72'({1'b1, 1'b0, 1'b0, 1'b0, 64'd12}));
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_after", 72'({bus.rsp_valid, bus.alu_rs1}), 72'({1'b0, 64'd5}));
        @(posedge clk); #1;

        // 2: both valid after reset -> req0 then req1.
        do_reset();
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 64'hF0, 64'h3C, 4'd0);
        set_req(1'b1, 1'b1, 64'hFF00, 64'h0FF0, 4'd0);
        @(negedge clk);
        check("t2_first", 72'(rdy()), 72'b10);
        @(posedge clk); #1;
        set_valid(1'b0, 1'b0);
        @(negedge clk);
        check("t2_exec_ready", 72'(rdy()), 72'b00);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_rsp0", 72'(rsp_vec()), 72'({1'b1, 1'b0, 1'b0, 1'b0, 64'h30}));
`ifdef ALU_ARB_PIPE_EN
        check("t2_second_pipe", 72'(rdy()), 72'b01);
`else
        check("t2_resp_ready", 72'(rdy()), 72'b00);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_second", 72'(rdy()), 72'b01);
`endif
        @(posedge clk); #1;
        set_valid(1'b1, 1'b0);
        wait_rsp("t2_rsp1", {1'b1, 1'b1, 1'b0, 1'b0, 64'hF00}, 4, lat);
        check("t2_rr", 72'(dbg_rr), 72'd0);

        // 3: req1 SUB with signed overflow.
        set_req(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 4'd3);
        wait_ready("t3_gnt", 1'b1, 2, lat);
        wait_rsp("t3_rsp", {1'b1, 1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF}, 3, lat);
        check("t3_lat", 72'(lat), 72'd1);

        // 4: backpressure holds the response and blocks req1.
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 64'd0, 64'd0, 4'd1);
        set_req(1'b1, 1'b1, 64'd3, 64'd4, 4'd2);
        @(negedge clk);
        check("t4_gnt", 72'(rdy()), 72'b10);
        @(posedge clk); #1;
        set_valid(1'b0, 1'b0);
        @(negedge clk);
        check("t4_exec_ready", 72'(rdy()), 72'b00);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_hold", 72'({rsp_vec(), rdy()}), 72'({1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 2'b00}));
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_take", 72'(rsp_vec()), 72'({1'b1, 1'b0, 1'b0, 1'b1, 64'd0}));
`ifdef ALU_ARB_PIPE_EN
        check("t4_req1_pipe", 72'(rdy()), 72'b01);
        @(posedge clk); #1;
`else
        check("t4_req1_wait", 72'(rdy()), 72'b00);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_req1", 72'(rdy()), 72'b01);
        @(posedge clk); #1;
`endif
        set_valid(1'b1, 1'b0);
        wait_rsp("t4_rsp1", {1'b1, 1'b1, 1'b0, 1'b0, 64'd7}, 4, lat);

        // 5: reset during EXEC discards the op and restores rr to req0.
        set_req(1'b0, 1'b1, 64'd9, 64'd9, 4'd3);
        @(negedge clk);
        check("t5_gnt", 72'(rdy()), 72'b10);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 64'd1, 64'd2, 4'd2);
        set_req(1'b1, 1'b1, 64'd5, 64'd6, 4'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_ctrl", 72'({rdy(), bus.rsp_valid, bus.rsp_id, dbg_state, dbg_rr}), 72'd0);
        check("t5_async_alu", 72'({bus.alu_rs1[31:0], bus.alu_rs2[31:0], bus.alu_code}), 72'd0);
        set_valid(1'b0, 1'b0);
        set_valid(1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_rsp", 72'(bus.rsp_valid), 72'd0);
            @(posedge clk); #1;
        end
        set_req(1'b0, 1'b1, 64'd9, 64'd9, 4'd3);
        set_req(1'b1, 1'b1, 64'd5, 64'd6, 4'd2);
        @(negedge clk);
        check("t5_after_rst", 72'(rdy()), 72'b10);
        @(posedge clk); #1;
        set_valid(1'b0, 1'b0);
        set_valid(1'b1, 1'b0);
        wait_rsp("t5_rsp", {1'b1, 1'b0, 1'b0, 1'b1, 64'd0}, 4, lat);

        // 6: saturated load, alternating ids; span of 10 ops measured grant-to-grant.
        do_reset();
        run_model(36, 1'b1, first_g, g11);
        check("t6_span", 72'(g11 - first_g), PIPE ? 72'd20 : 72'd30);

        // Random traffic with backpressure and dropped valids.
        do_reset();
        run_model(700, 1'b0, first_g, g11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
